// File: rtl/sifo_pkg.sv
// sifo_pkg: shared widths and loader state encoding for the stream/RAM boot path
package sifo_pkg;
    localparam int DATA_W = 10;
    localparam int ADDR_W = 14;
    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE, LD_ERR} loader_state_t;
endpackage

// File: rtl/mem_loader.sv
// mem_loader: streams a checksummed boot image into data RAM and holds the CPU in reset until it verifies
module mem_loader #(
    parameter int DATA_W    = sifo_pkg::DATA_W,
    parameter int ADDR_W    = sifo_pkg::ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);
    import sifo_pkg::*;
    loader_state_t state, state_d;
    logic [DATA_W-1:0] acc;
    logic xfer, sum_ok, full, data_xfer, overflow, start_load;
    assign s_ready    = state == LD_LOAD;
    assign xfer       = s_valid && s_ready;
    assign sum_ok     = s_data == acc;
    assign full       = word_count == (ADDR_W+1)'(DEPTH);
    assign data_xfer  = xfer && !s_last && !full;
    assign overflow   = xfer && !s_last && full;
    assign start_load = start && state != LD_LOAD;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= LD_IDLE;
        else state <= state_d;
    end
    // Next state: start only acts outside LOAD; the frame ends on the checksum word or on overflow
    always_comb begin
        state_d = state;
        if (state == LD_LOAD) begin
            if (xfer && s_last) state_d = sum_ok ? LD_DONE : LD_ERR;
            else if (overflow) state_d = LD_ERR;
        end else if (start) state_d = LD_LOAD;
    end
    // Datapath: registered RAM write per data word, running checksum, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= ADDR_W'(BASE_ADDR);
            mem_data   <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            acc        <= '0;
        end else begin
            mem_we <= data_xfer;
            if (start_load) begin
                mem_addr   <= ADDR_W'(BASE_ADDR);
                cpu_rst    <= 1'b1;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
                word_count <= '0;
                acc        <= '0;
            end
            if (data_xfer) begin
                mem_addr   <= ADDR_W'(BASE_ADDR) + word_count[ADDR_W-1:0];
                mem_data   <= s_data;
                acc        <= acc + s_data;
                word_count <= word_count + 1'b1;
            end
            if (xfer && s_last) begin
                load_done <= sum_ok;
                load_err  <= !sum_ok;
                cpu_rst   <= !sum_ok;
            end
            if (overflow) load_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for the boot-image loader, one task per scenario
module tb_mem_loader;
    localparam int DW = 10;
    localparam int AW = 14;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0, s_last = 1'b0, sel = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic rdy_b, we_b, cr_b, done_b, err_b, rdy_s, we_s, cr_s, done_s, err_s;
    logic [AW-1:0] addr_b, addr_s;
    logic [DW-1:0] data_b, data_s;
    logic [AW:0] wc_b, wc_s;
    logic rdy, we, cpu_rst, done, err;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW:0] wc;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [AW+DW-1:0] exp_q [$];
    int tests = 0, fails = 0, wr_cnt = 0, first_cyc = -1, last_cyc = 0, cyc = 0;

    mem_loader dut_b (.clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(rdy_b),
        .s_data(s_data), .s_last(s_last), .mem_we(we_b), .mem_addr(addr_b), .mem_data(data_b),
        .cpu_rst(cr_b), .load_done(done_b), .load_err(err_b), .word_count(wc_b));
    mem_loader #(.DEPTH(4)) dut_s (.clk(clk), .rst(rst), .start(start), .s_valid(s_valid),
        .s_ready(rdy_s), .s_data(s_data), .s_last(s_last), .mem_we(we_s), .mem_addr(addr_s),
        .mem_data(data_s), .cpu_rst(cr_s), .load_done(done_s), .load_err(err_s), .word_count(wc_s));

    assign rdy     = sel ? rdy_s  : rdy_b;
    assign we      = sel ? we_s   : we_b;
    assign addr    = sel ? addr_s : addr_b;
    assign data    = sel ? data_s : data_b;
    assign cpu_rst = sel ? cr_s   : cr_b;
    assign done    = sel ? done_s : done_b;
    assign err     = sel ? err_s  : err_b;
    assign wc      = sel ? wc_s   : wc_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (we) ram[addr] <= data;

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_data = '0; idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input logic [AW-1:0] a, input logic push);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        if (push) exp_q.push_back({a, d});
        @(negedge clk);
        while (!rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL send_ready data=%0d got=%b want=1", d, rdy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic monitor(input int cycles);
        logic [AW+DW-1:0] e;
        wr_cnt = 0; first_cyc = -1;
        repeat (cycles) begin
            @(negedge clk);
            if (we === 1'b1) begin
                wr_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected got addr=%0d data=%0d want no write", addr, data);
                end else begin
                    e = exp_q.pop_front();
                    if ({addr, data} !== e) begin
                        fails++;
                        $display("FAIL write got addr=%0d data=%0d want addr=%0d data=%0d",
                            addr, data, e[AW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL writes_missing got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        tests++;
        if ({rdy, we, addr, data, cpu_rst, done, err, wc} !== {1'b0, 1'b0, 14'd0, 10'd0, 1'b1, 1'b0, 1'b0, 15'd0}) begin
            fails++;
            $display("FAIL reset_state got %h want %h", {rdy, we, addr, data, cpu_rst, done, err, wc},
                {1'b0, 1'b0, 14'd0, 10'd0, 1'b1, 1'b0, 1'b0, 15'd0});
        end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        do_reset();
        pulse_start();
        fork
            begin
                send(10'd3, 1'b0, 14'd0, 1'b1);
                send(10'd5, 1'b0, 14'd1, 1'b1);
                send(10'd7, 1'b0, 14'd2, 1'b1);
                send(10'd15, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, cpu_rst, err, wc} !== {1'b1, 1'b0, 1'b0, 15'd3}) begin
                    fails++;
                    $display("FAIL basic_done got done=%b cpu_rst=%b err=%b wc=%0d want 1 0 0 3", done, cpu_rst, err, wc);
                end
            end
            monitor(10);
        join
        tests++;
        if (wr_cnt != 3 || last_cyc - first_cyc != 2) begin
            fails++;
            $display("FAIL basic_spacing got writes=%0d span=%0d want 3 2", wr_cnt, last_cyc - first_cyc);
        end
    endtask

    task automatic test_bad_checksum();
        sel = 1'b0;
        do_reset();
        pulse_start();
        fork
            begin
                send(10'd3, 1'b0, 14'd0, 1'b1);
                send(10'd5, 1'b0, 14'd1, 1'b1);
                send(10'd7, 1'b0, 14'd2, 1'b1);
                send(10'd14, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, cpu_rst, err} !== 3'b011) begin
                    fails++;
                    $display("FAIL bad_sum_flags got done=%b cpu_rst=%b err=%b want 0 1 1", done, cpu_rst, err);
                end
            end
            monitor(10);
        join
        tests++;
        if ({ram[0], ram[1], ram[2]} !== {10'd3, 10'd5, 10'd7}) begin
            fails++;
            $display("FAIL bad_sum_ram got %0d %0d %0d want 3 5 7", ram[0], ram[1], ram[2]);
        end
    endtask

    task automatic test_long();
        logic [DW-1:0] sum = '0;
        sel = 1'b0;
        do_reset();
        pulse_start();
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                    send(10'd1023, 1'b0, AW'(i), 1'b1);
                    sum = sum + 10'd1023;
                end
                send(sum, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, cpu_rst, wc, sum} !== {1'b1, 1'b0, 15'd1000, 10'd24}) begin
                    fails++;
                    $display("FAIL long_done got done=%b cpu_rst=%b wc=%0d sum=%0d want 1 0 1000 24", done, cpu_rst, wc, sum);
                end
            end
            monitor(2100);
        join
        tests++;
        if (wr_cnt != 1000) begin
            fails++;
            $display("FAIL long_count got %0d want 1000", wr_cnt);
        end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        do_reset();
        pulse_start();
        fork
            begin
                for (int i = 0; i < 5; i++) send(DW'(20 + i), 1'b0, AW'(i), i < 4);
                idle();
                tests++;
                if ({err, done, cpu_rst, rdy, wc} !== {1'b1, 1'b0, 1'b1, 1'b0, 15'd4}) begin
                    fails++;
                    $display("FAIL overflow_flags got err=%b done=%b cpu_rst=%b rdy=%b wc=%0d want 1 0 1 0 4", err, done, cpu_rst, rdy, wc);
                end
            end
            monitor(12);
        join
        tests++;
        if (wr_cnt != 4) begin
            fails++;
            $display("FAIL overflow_count got %0d want 4", wr_cnt);
        end
        sel = 1'b0;
    endtask

    task automatic test_rst_abort();
        sel = 1'b0;
        do_reset();
        pulse_start();
        fork
            begin
                send(10'd1, 1'b0, 14'd0, 1'b1);
                send(10'd2, 1'b0, 14'd1, 1'b1);
                rst = 1'b1;
                idle();
                @(posedge clk);
                #1;
                tests++;
                if ({rdy, we, addr, data, cpu_rst, done, err, wc} !== {1'b0, 1'b0, 14'd0, 10'd0, 1'b1, 1'b0, 1'b0, 15'd0}) begin
                    fails++;
                    $display("FAIL abort_state got %h want %h", {rdy, we, addr, data, cpu_rst, done, err, wc},
                        {1'b0, 1'b0, 14'd0, 10'd0, 1'b1, 1'b0, 1'b0, 15'd0});
                end
                rst = 1'b0;
                pulse_start();
                for (int i = 0; i < 4; i++) send(DW'(10 + i), 1'b0, AW'(i), 1'b1);
                send(10'd46, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, cpu_rst, wc} !== {1'b1, 1'b0, 15'd4}) begin
                    fails++;
                    $display("FAIL abort_reload got done=%b cpu_rst=%b wc=%0d want 1 0 4", done, cpu_rst, wc);
                end
            end
            monitor(24);
        join
    endtask

    task automatic test_empty_frame();
        sel = 1'b0;
        do_reset();
        pulse_start();
        fork
            begin
                send(10'd0, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, err, cpu_rst, wc} !== {1'b1, 1'b0, 1'b0, 15'd0}) begin
                    fails++;
                    $display("FAIL empty_good got done=%b err=%b cpu_rst=%b wc=%0d want 1 0 0 0", done, err, cpu_rst, wc);
                end
                pulse_start();
                tests++;
                if ({done, cpu_rst, rdy} !== 3'b011) begin
                    fails++;
                    $display("FAIL restart_clear got done=%b cpu_rst=%b rdy=%b want 0 1 1", done, cpu_rst, rdy);
                end
                send(10'd1, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, err, cpu_rst} !== 3'b011) begin
                    fails++;
                    $display("FAIL empty_bad got done=%b err=%b cpu_rst=%b want 0 1 1", done, err, cpu_rst);
                end
                pulse_start();
                send(10'd4, 1'b0, 14'd0, 1'b1);
                start = 1'b1;
                send(10'd6, 1'b0, 14'd1, 1'b1);
                start = 1'b0;
                send(10'd10, 1'b1, 14'd0, 1'b0);
                idle();
                tests++;
                if ({done, err, wc} !== {1'b1, 1'b0, 15'd2}) begin
                    fails++;
                    $display("FAIL start_in_load got done=%b err=%b wc=%0d want 1 0 2", done, err, wc);
                end
            end
            monitor(30);
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_long();
        test_overflow();
        test_rst_abort();
        test_empty_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
